// File: rtl/i2c_target_model.sv
// I2C target (slave) model with a small byte-addressed register file and an auto-incrementing pointer.
// Optional general-call support is enabled by defining I2C_TARGET_GENCALL_EN.
module i2c_target_model #(
  parameter logic [6:0] DEV_ADDR  = 7'h21,
  parameter int         MEM_DEPTH = 16,
  parameter int         PTR_W     = 4
) (
  input  logic             core_clk,
  input  logic             rst,
  input  logic             scl,
  input  logic             sda_in,
  output logic             sda_oe,
  input  logic             nack_inject,
  input  logic [PTR_W-1:0] dbg_addr,
  output logic [7:0]       dbg_data,
  output logic [7:0]       byte_cnt,
  output logic             busy,
  output logic [3:0]       state_dbg
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR     = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK = 4'd2;
  localparam logic [3:0] ST_PTR      = 4'd3;
  localparam logic [3:0] ST_PTR_ACK  = 4'd4;
  localparam logic [3:0] ST_WDATA    = 4'd5;
  localparam logic [3:0] ST_WACK     = 4'd6;
  localparam logic [3:0] ST_RDATA    = 4'd7;
  localparam logic [3:0] ST_RACK_CHK = 4'd8;
  localparam logic [3:0] ST_IGNORE   = 4'd9;

  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;

  logic [3:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic             busy_q, busy_d;
  logic             sda_oe_q, sda_oe_d;
  logic             rw_q, rw_d;
  logic             gcall_q, gcall_d;

  logic [7:0]       mem_q [MEM_DEPTH];
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;

  logic             scl_rise, scl_fall, start_det, stop_det, rd_bit;
  logic [7:0]       rx_byte, cnt_inc;
  logic [PTR_W-1:0] ptr_inc;

  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
  assign rx_byte   = {shift_q, sda_s2_q};
  assign rd_bit    = mem_q[ptr_q][3'd7 - bit_cnt_q];
  assign cnt_inc   = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
  assign ptr_inc   = ptr_q + PTR_W'(1);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    byte_cnt_d = byte_cnt_q;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;
    rw_d       = rw_q;
    gcall_d    = gcall_q;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    // Bus conditions outrank any SCL edge seen in the same cycle.
    if (start_det) begin
      state_d    = ST_ADDR;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      sda_oe_d   = 1'b0;
      gcall_d    = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_ADDR) begin
                rw_d = rx_byte[0];
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
`ifdef I2C_TARGET_GENCALL_EN
                end else if (rx_byte == 8'h00) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                  gcall_d = 1'b1;
`endif
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = rx_byte[PTR_W-1:0];
                state_d = ST_PTR_ACK;
              end else if (nack_inject) begin
                state_d = ST_IGNORE;
              end else begin
                mem_we     = 1'b1;
                byte_cnt_d = cnt_inc;
                state_d    = ST_WACK;
                if (gcall_q) mem_waddr = PTR_W'(MEM_DEPTH - 1);
                else         ptr_d     = ptr_inc;
              end
            end
          end
        end
        // ACK slot: first SCL fall pulls SDA, the next one releases it and moves on.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_d  = ST_RDATA;
                sda_oe_d = ~mem_q[ptr_q][7];
              end else if (state_q == ST_WACK && gcall_q) begin
                state_d = ST_IGNORE;
              end else if (state_q == ST_ADDR_ACK && !gcall_q) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            sda_oe_d = ~rd_bit;
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_RACK_CHK;
          end
        end
        ST_RACK_CHK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_s2_q) begin
              ptr_d      = ptr_inc;
              byte_cnt_d = cnt_inc;
              state_d    = ST_RDATA;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_IDLE, ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
      gcall_q    <= 1'b0;
    end else begin
      scl_s1_q   <= scl;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= sda_in;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
      rw_q       <= rw_d;
      gcall_q    <= gcall_d;
    end
  end

  // Register file keeps its contents through reset.
  always_ff @(posedge core_clk) begin
    if (mem_we && !rst) mem_q[mem_waddr] <= rx_byte;
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign byte_cnt  = byte_cnt_q;
  assign dbg_data  = mem_q[dbg_addr];
  assign state_dbg = state_q;

endmodule

// File: doc/i2c_target_model.md
I2C_TARGET_MODEL -- requirements
Module: i2c_target_model

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h21, meaning the 7-bit target address it answers.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 16, meaning the register-file depth in bytes (power of two, 2..256).
REQ-003 The block SHALL have parameter PTR_W, default 4, meaning the pointer width, equal to log2(MEM_DEPTH).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port core_clk, input, 1 bit, meaning the sampling clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning the synchronous active-high reset.
REQ-007 The block SHALL have port scl, input, 1 bit, meaning the bus clock as seen on the wire.
REQ-008 The block SHALL have port sda_in, input, 1 bit, meaning the bus data as seen on the wire.
REQ-009 The block SHALL have port sda_oe, output, 1 bit, meaning pull SDA low when 1 (open-drain; the bench resolves the tri-state).
REQ-010 The block SHALL have port nack_inject, input, 1 bit, meaning the next write-data byte is NACKed when 1.
REQ-011 The block SHALL have port dbg_addr, input, PTR_W bits, meaning the bench read address into the register file.
REQ-012 The block SHALL have port dbg_data, output, 8 bits, meaning mem[dbg_addr], combinational.
REQ-013 The block SHALL have port byte_cnt, output, 8 bits, meaning data bytes ACKed since the last START (saturates at 255).
REQ-014 The block SHALL have port busy, output, 1 bit, meaning 1 from an address match until STOP.

Function
REQ-015 scl and sda_in SHALL pass through 2-flop synchronisers; edge and START/STOP detection SHALL use the synchronised values, giving 2-3 cycles of latency.
REQ-016 A START (SDA falling while SCL high) or repeated START SHALL force state ADDR from any state, clear byte_cnt and the bit counter, and release sda_oe.
REQ-017 A STOP (SDA rising while SCL high) SHALL force state IDLE from any state, deassert busy, and release sda_oe.
REQ-018 Bits SHALL be sampled MSB first on synchronised SCL rising edges.
REQ-019 The state machine SHALL have states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK_CHK, IGNORE.
REQ-020 After 8 address bits, if addr[7:1] matches DEV_ADDR, the block SHALL go to ADDR_ACK; otherwise it SHALL go to IGNORE until the next START or STOP.
REQ-021 sda_oe SHALL change only on the first core_clk cycle after a synchronised SCL falling edge.
REQ-022 For an ACK, sda_oe SHALL be asserted after the 8th SCL fall and released after the 9th SCL fall.
REQ-023 With R/W=0, the first byte SHALL load the pointer (low PTR_W bits used, upper bits ignored) and SHALL be ACKed; that byte SHALL not count in byte_cnt.
REQ-024 Each subsequent write byte SHALL be stored at mem[ptr] on the 8th SCL rise and ACKed; the pointer SHALL then increment and byte_cnt SHALL increment.
REQ-025 If nack_inject=1 when a write byte's 8th bit is sampled, that byte SHALL not be stored, SHALL be NACKed, and the block SHALL go to IGNORE.
REQ-026 With R/W=1, the block SHALL drive !mem[ptr][7-i] on sda_oe for bit i, each bit set after the SCL fall, starting with the fall that ends ADDR_ACK.
REQ-027 After the 8 read-data bits, the block SHALL release sda_oe and sample the master's ACK on the 9th SCL rise.
REQ-028 A master ACK SHALL increment ptr and byte_cnt and continue in RDATA; a master NACK SHALL go to IGNORE.
REQ-029 The pointer SHALL wrap from MEM_DEPTH-1 to 0.
REQ-030 The pointer SHALL persist across transactions, so a write-pointer-only transfer followed by a repeated START and read reads from that pointer.
REQ-031 On a simultaneous SCL edge and START/STOP in one cycle, START/STOP SHALL take priority.

Reset
REQ-032 While rst=1, the block SHALL hold state=IDLE, sda_oe=0, busy=0, byte_cnt=0, ptr=0, and synchronisers=1.
REQ-033 Register-file contents SHALL NOT be reset.
REQ-034 A reset mid-transfer SHALL release SDA within 1 cycle, and the block SHALL ignore the bus until the next START.

Configuration
REQ-035 With I2C_TARGET_GENCALL_EN defined, address byte 8'h00 SHALL be ACKed.
REQ-036 With I2C_TARGET_GENCALL_EN defined, the byte following a general call SHALL be stored at mem[MEM_DEPTH-1] without altering ptr, and the block SHALL then go to IGNORE.
REQ-037 Without I2C_TARGET_GENCALL_EN, address 8'h00 SHALL be treated as a mismatch, with no ACK.

Verification
REQ-038 Write START, 0x42, 0x03, 0x01, 0x02, STOP -> 4 ACKs; mem[3]=0x01, mem[4]=0x02; byte_cnt=2; busy low after STOP.
REQ-039 Write ptr 0x0F then 0xAA, 0xBB -> mem[15]=0xAA, mem[0]=0xBB (wrap).
REQ-040 Write ptr 0x03, repeated START, 0x43, read 2 bytes with ACK then NACK -> SDA carries 0x01, 0x02; state IGNORE; STOP -> IDLE.
REQ-041 Address 0x44 -> no ACK (sda_oe stays 0 for the whole transfer); busy stays 0.
REQ-042 nack_inject=1 on the 2nd data byte -> 1st byte stored, 2nd byte not stored; 9th-bit SDA high.
REQ-043 Reset asserted during bit 5 of a data byte -> sda_oe=0 next cycle; the following START/0x42 transfer is ACKed normally.
